// File: rtl/pin_entry_ctrl_if.sv
// Button inputs and status outputs of the PIN entry controller.
// master = button front-end / wallet side, slave = controller.
interface pin_entry_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  b_esq_i;
  logic                  b_dir_i;
  logic [3:0]            digit_o;
  logic [1:0]            pos_o;
  logic [4*DIGITS-1:0]   pin_vec_o;
  logic                  set_done_o;
  logic                  unlock_o;
  logic                  fail_o;
  logic                  locked_o;

  modport master (
    output b_esq_i,
    output b_dir_i,
    input  digit_o,
    input  pos_o,
    input  pin_vec_o,
    input  set_done_o,
    input  unlock_o,
    input  fail_o,
    input  locked_o
  );

  modport slave (
    input  b_esq_i,
    input  b_dir_i,
    output digit_o,
    output pos_o,
    output pin_vec_o,
    output set_done_o,
    output unlock_o,
    output fail_o,
    output locked_o
  );
endinterface

// File: rtl/pin_entry_ctrl.sv
// Two-button BCD PIN entry: stores a PIN, verifies later
// entries, and enforces a retry limit with a timed lockout.
module pin_entry_ctrl #(
  parameter int DIGITS      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  pin_entry_ctrl_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(MAX_TRIES + 1);
  localparam int TW = $clog2(LOCK_CYCLES + 1);

  localparam logic [1:0] S_SETUP  = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_UNLOCK = 2'd2;
  localparam logic [1:0] S_LOCK   = 2'd3;

  logic [1:0]    r_state;
  logic          r_esq_q;
  logic          r_dir_q;
  logic [3:0]    r_digit;
  logic [1:0]    r_pos;
  logic [BW-1:0] r_buf;
  logic [BW-1:0] r_pin;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_tmr;
  logic          r_set_done;
  logic          r_unlock;
  logic          r_fail;
  logic          r_locked;

  logic          w_esq_rise;
  logic          w_dir_rise;
  logic          w_last;
  logic [BW-1:0] w_word;
  logic [CW-1:0] w_cnt_inc;

  assign w_esq_rise = bus.b_esq_i & ~r_esq_q;
  assign w_dir_rise = bus.b_dir_i & ~r_dir_q;
  assign w_last     = (r_pos == 2'(DIGITS - 1));
  assign w_cnt_inc  = r_cnt + 1'b1;

  // Buffer with the digit being confirmed already merged in
  always_comb begin
    w_word = r_buf;
    w_word[4*r_pos +: 4] = r_digit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_SETUP;
      r_esq_q    <= 1'b0;
      r_dir_q    <= 1'b0;
      r_digit    <= '0;
      r_pos      <= '0;
      r_buf      <= '0;
      r_pin      <= '0;
      r_cnt      <= '0;
      r_tmr      <= '0;
      r_set_done <= 1'b0;
      r_unlock   <= 1'b0;
      r_fail     <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_esq_q    <= bus.b_esq_i;
      r_dir_q    <= bus.b_dir_i;
      r_set_done <= 1'b0;
      r_fail     <= 1'b0;
      case (r_state)
        S_SETUP, S_VERIFY: begin
          if (w_esq_rise) begin
            r_digit <= '0;
            if (!w_last) begin
              r_pos <= r_pos + 2'd1;
              r_buf <= w_word;
            end else begin
              r_pos <= '0;
              r_buf <= '0;
              if (r_state == S_SETUP) begin
                r_pin      <= w_word;
                r_set_done <= 1'b1;
                r_state    <= S_VERIFY;
              end else if (w_word == r_pin) begin
                r_unlock <= 1'b1;
                r_cnt    <= '0;
                r_state  <= S_UNLOCK;
              end else begin
                r_fail <= 1'b1;
                if (w_cnt_inc == CW'(MAX_TRIES)) begin
                  r_cnt    <= '0;
                  r_tmr    <= TW'(LOCK_CYCLES - 1);
                  r_locked <= 1'b1;
                  r_state  <= S_LOCK;
                end else begin
                  r_cnt <= w_cnt_inc;
                end
              end
            end
          end else if (w_dir_rise) begin
            r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
          end
        end
        S_UNLOCK: begin
          if (w_esq_rise) begin
            r_unlock <= 1'b0;
            r_digit  <= '0;
            r_pos    <= '0;
            r_buf    <= '0;
            r_state  <= S_VERIFY;
          end
        end
        S_LOCK: begin
          if (r_tmr == '0) begin
            r_locked <= 1'b0;
            r_state  <= S_VERIFY;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        default: r_state <= S_SETUP;
      endcase
    end
  end

  assign bus.digit_o    = r_digit;
  assign bus.pos_o      = r_pos;
  assign bus.pin_vec_o  = r_pin;
  assign bus.set_done_o = r_set_done;
  assign bus.unlock_o   = r_unlock;
  assign bus.fail_o     = r_fail;
  assign bus.locked_o   = r_locked;
endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Directed bench for pin_entry_ctrl: setup, verify, wrap,
// lockout timing, simultaneous buttons and reset recovery.
module tb_pin_entry_ctrl;
  localparam int LC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  pin_entry_ctrl_if #(.DIGITS(4)) bus ();

  pin_entry_ctrl #(
    .DIGITS(4),
    .MAX_TRIES(3),
    .LOCK_CYCLES(LC)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

  task automatic press_dir();
    @(negedge clk);
    bus.b_dir_i = 1'b1;
    @(negedge clk);
    bus.b_dir_i = 1'b0;
  endtask

  task automatic press_esq();
    @(negedge clk);
    bus.b_esq_i = 1'b1;
    @(negedge clk);
    bus.b_esq_i = 1'b0;
  endtask

  task automatic dial(input int n);
    repeat (n) press_dir();
    press_esq();
  endtask

  task automatic test_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_assert++;
    if ({bus.digit_o, bus.pos_o} !== 6'd0) begin
      n_fail++;
      $display("FAIL %s_digit_pos: got %h/%h want 0/0",
               tag, bus.digit_o, bus.pos_o);
    end
    n_assert++;
    if (bus.pin_vec_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL %s_pin: got %h want 0000",
               tag, bus.pin_vec_o);
    end
    n_assert++;
    if ({bus.set_done_o, bus.unlock_o,
         bus.fail_o, bus.locked_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s_flags: got %b%b%b%b want 0000", tag,
               bus.set_done_o, bus.unlock_o,
               bus.fail_o, bus.locked_o);
    end
  endtask

  task automatic test_setup();
    dial(1);
    n_assert++;
    if (bus.pos_o !== 2'd1 || bus.digit_o !== 4'd0) begin
      n_fail++;
      $display("FAIL setup_pos1: got %0d/%0d want 1/0",
               bus.pos_o, bus.digit_o);
    end
    dial(2);
    dial(3);
    repeat (4) press_dir();
    n_assert++;
    if (bus.digit_o !== 4'd4) begin
      n_fail++;
      $display("FAIL setup_digit4: got %0d want 4", bus.digit_o);
    end
    press_esq();
    n_assert++;
    if (bus.set_done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL setup_done: got %b want 1", bus.set_done_o);
    end
    n_assert++;
    if (bus.pin_vec_o !== 16'h4321) begin
      n_fail++;
      $display("FAIL setup_pin: got %h want 4321", bus.pin_vec_o);
    end
    n_assert++;
    if (bus.pos_o !== 2'd0 || bus.digit_o !== 4'd0) begin
      n_fail++;
      $display("FAIL setup_clear: got %0d/%0d want 0/0",
               bus.pos_o, bus.digit_o);
    end
    @(negedge clk);
    n_assert++;
    if (bus.set_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL setup_pulse: got %b want 0", bus.set_done_o);
    end
  endtask

  task automatic test_unlock();
    dial(1);
    dial(2);
    dial(3);
    repeat (4) press_dir();
    n_assert++;
    if (bus.unlock_o !== 1'b0) begin
      n_fail++;
      $display("FAIL unlock_early: got %b want 0", bus.unlock_o);
    end
    press_esq();
    n_assert++;
    if (bus.unlock_o !== 1'b1 || bus.fail_o !== 1'b0) begin
      n_fail++;
      $display("FAIL unlock_set: got u=%b f=%b want u=1 f=0",
               bus.unlock_o, bus.fail_o);
    end
    press_dir();
    n_assert++;
    if (bus.digit_o !== 4'd0 || bus.unlock_o !== 1'b1) begin
      n_fail++;
      $display("FAIL unlock_dir_ignored: got d=%0d u=%b want 0/1",
               bus.digit_o, bus.unlock_o);
    end
    press_esq();
    n_assert++;
    if (bus.unlock_o !== 1'b0) begin
      n_fail++;
      $display("FAIL unlock_relock: got %b want 0", bus.unlock_o);
    end
  endtask

  task automatic test_wrap();
    repeat (11) press_dir();
    n_assert++;
    if (bus.digit_o !== 4'd1) begin
      n_fail++;
      $display("FAIL wrap_digit: got %0d want 1", bus.digit_o);
    end
    press_esq();
    @(negedge clk);
    bus.b_dir_i = 1'b1;
    repeat (20) @(negedge clk);
    bus.b_dir_i = 1'b0;
    n_assert++;
    if (bus.digit_o !== 4'd1) begin
      n_fail++;
      $display("FAIL hold_once: got %0d want 1", bus.digit_o);
    end
    press_dir();
    press_esq();
    dial(3);
    dial(4);
    n_assert++;
    if (bus.unlock_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_unlock: got %b want 1", bus.unlock_o);
    end
    press_esq();
  endtask

  task automatic test_lockout();
    int cnt;
    for (int t = 0; t < 3; t++) begin
      repeat (4) press_esq();
      n_assert++;
      if (bus.fail_o !== 1'b1 || bus.unlock_o !== 1'b0) begin
        n_fail++;
        $display("FAIL lock_fail%0d: got f=%b u=%b want 1/0",
                 t, bus.fail_o, bus.unlock_o);
      end
      n_assert++;
      if (bus.locked_o !== (t == 2)) begin
        n_fail++;
        $display("FAIL lock_state%0d: got %b want %b",
                 t, bus.locked_o, (t == 2));
      end
      if (t < 2) begin
        @(negedge clk);
        n_assert++;
        if (bus.fail_o !== 1'b0) begin
          n_fail++;
          $display("FAIL lock_pulse%0d: got %b want 0",
                   t, bus.fail_o);
        end
      end
    end
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.locked_o !== 1'b1) break;
      cnt++;
      n_assert++;
      if (bus.digit_o !== 4'd0 || bus.pos_o !== 2'd0 ||
          bus.unlock_o !== 1'b0) begin
        n_fail++;
        $display("FAIL lock_ignore: got d=%0d p=%0d u=%b",
                 bus.digit_o, bus.pos_o, bus.unlock_o);
      end
      bus.b_dir_i = i[0];
      bus.b_esq_i = i[1];
      @(negedge clk);
    end
    bus.b_dir_i = 1'b0;
    bus.b_esq_i = 1'b0;
    n_assert++;
    if (cnt != LC) begin
      n_fail++;
      $display("FAIL lock_len: got %0d want %0d", cnt, LC);
    end
    dial(1);
    dial(2);
    dial(3);
    dial(4);
    n_assert++;
    if (bus.unlock_o !== 1'b1 || bus.locked_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_after: got u=%b l=%b want 1/0",
               bus.unlock_o, bus.locked_o);
    end
    press_esq();
  endtask

  task automatic test_mid_entry_reset();
    dial(1);
    dial(2);
    repeat (3) press_dir();
    n_assert++;
    if (bus.pos_o !== 2'd2 || bus.digit_o !== 4'd3) begin
      n_fail++;
      $display("FAIL mid_entry_pre: got %0d/%0d want 2/3",
               bus.pos_o, bus.digit_o);
    end
    test_reset("mid_entry");
  endtask

  task automatic test_both();
    repeat (5) press_dir();
    @(negedge clk);
    bus.b_esq_i = 1'b1;
    bus.b_dir_i = 1'b1;
    @(negedge clk);
    bus.b_esq_i = 1'b0;
    bus.b_dir_i = 1'b0;
    n_assert++;
    if (bus.digit_o !== 4'd0 || bus.pos_o !== 2'd1) begin
      n_fail++;
      $display("FAIL both_step: got d=%0d p=%0d want 0/1",
               bus.digit_o, bus.pos_o);
    end
    repeat (3) press_esq();
    n_assert++;
    if (bus.set_done_o !== 1'b1 || bus.pin_vec_o !== 16'h0005) begin
      n_fail++;
      $display("FAIL both_pin: got sd=%b pin=%h want 1/0005",
               bus.set_done_o, bus.pin_vec_o);
    end
  endtask

  task automatic test_mid_lock_reset();
    repeat (3) begin
      dial(1);
      repeat (3) press_esq();
    end
    n_assert++;
    if (bus.locked_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_lock_pre: got %b want 1", bus.locked_o);
    end
    repeat (5) @(negedge clk);
    test_reset("mid_lock");
    dial(7);
    repeat (3) press_esq();
    n_assert++;
    if (bus.set_done_o !== 1'b1 || bus.pin_vec_o !== 16'h0007) begin
      n_fail++;
      $display("FAIL post_reset_setup: got sd=%b pin=%h want 1/0007",
               bus.set_done_o, bus.pin_vec_o);
    end
  endtask

  initial begin
    bus.b_esq_i = 1'b0;
    bus.b_dir_i = 1'b0;
    repeat (2) @(negedge clk);
    test_reset("reset");
    test_setup();
    test_unlock();
    test_wrap();
    test_lockout();
    test_mid_entry_reset();
    test_both();
    test_mid_lock_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pin_entry_ctrl.md
Name: pin_entry_ctrl

Overview:
Sequencing controller for the wallet PIN datapath. It turns two debounced push-buttons into a 4-digit BCD PIN. It stores the PIN on first use, then verifies later entries against it and drives the unlock flag. It also enforces a retry limit with a timed lockout, and sits between the button front-end and the wallet access logic.

Parameters:
DIGITS, 4, number of PIN digits (buffer width = 4*DIGITS)
MAX_TRIES, 3, consecutive failed verifications before lockout (>=1)
LOCK_CYCLES, 1000, clock cycles locked_o stays high per lockout (>=1)

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
b_esq_i  input  1  left button, debounced synchronous level; confirms current digit
b_dir_i  input  1  right button, debounced synchronous level; increments current digit
digit_o  output  4  digit currently being dialled, 0..9
pos_o  output  2  index of digit being entered, 0..DIGITS-1
pin_vec_o  output  4*DIGITS  stored PIN; digit k in bits [4k+3:4k]
set_done_o  output  1  one-cycle pulse: PIN stored
unlock_o  output  1  access granted (level)
fail_o  output  1  one-cycle pulse: verification mismatch
locked_o  output  1  lockout active (level)

Behaviour:
- Reset (sync, rst_i=1 at clk edge): state SETUP, digit_o=0, pos_o=0, entry buffer=0, pin_vec_o=0, fail counter=0, lock timer=0, all flags 0, edge-detect registers=0. Reset overrides all activity, including entry in progress or lockout.
- Edge detect: registered copy of each button. A rise means input=1 and previous=0. Only rises act; held buttons do nothing further.
- States:
  - SETUP: first PIN entry.
  - VERIFY: PIN entry compared against the stored PIN.
  - UNLOCKED: access granted.
  - LOCKOUT: timed retry block.
- Entry (SETUP, VERIFY):
  - b_dir rise: digit_o <= (digit_o==9) ? 0 : digit_o+1.
  - b_esq rise: buffer[4*pos+:4] <= digit_o; digit_o <= 0.
    - If pos_o < DIGITS-1: pos_o increments.
    - Else the entry completes; pos_o <= 0 and the buffer clears.
  - Same-cycle rise on both: b_esq wins; b_dir rise discarded.
- Completion in SETUP: pin_vec_o <= buffer including the final digit. set_done_o=1 for the following cycle. Next state VERIFY.
- Completion in VERIFY: the full entered word (final digit included) is compared to pin_vec_o.
  - Match: next state UNLOCKED; unlock_o=1 from the following cycle; fail counter <= 0.
  - Mismatch: fail_o=1 for one cycle; counter increments.
    - If the counter reaches MAX_TRIES: counter <= 0, timer <= LOCK_CYCLES-1, next state LOCKOUT.
    - Otherwise stay in VERIFY.
- Output timing: all outputs are registered. The response appears in the cycle after the clock edge that samples the rise (1-cycle latency from the button edge).
- UNLOCKED:
  - unlock_o held 1; b_dir ignored.
  - b_esq rise relocks: unlock_o <= 0, next state VERIFY, digit/pos cleared.
  - Stored PIN is unchanged; changing it requires reset.
- LOCKOUT:
  - locked_o=1 for exactly LOCK_CYCLES cycles; both buttons ignored, edge registers still track.
  - Timer decrements each cycle; at timer==0 next state VERIFY and locked_o <= 0.
  - A button held high across the exit is not treated as a rise.
- Counter and timer widths are sized by $clog2 of their parameters; no wrap.
- unlock_o and locked_o are never both 1. fail_o is never 1 while unlock_o=1.

Test Plan:
- Reset, then enter 1,2,3,4 (1 b_dir rise then b_esq; 2 rises then b_esq; and so on) -> pin_vec_o=16'h4321, set_done_o single pulse, state VERIFY, digit_o=0, pos_o=0.
- With PIN 16'h4321, enter 1,2,3,4 -> unlock_o=1 one cycle after the 4th b_esq rise. Then one b_esq rise -> unlock_o=0, back to VERIFY.
- Dial 11 b_dir rises then b_esq -> stored digit 1 (9 wraps to 0). Hold b_dir high 20 cycles -> digit increments once only.
- Three wrong entries (0000) with MAX_TRIES=3 -> fail_o pulses three times, locked_o=1 for exactly LOCK_CYCLES cycles. Button rises during lockout change nothing; a correct entry afterwards unlocks.
- b_esq and b_dir rise in the same cycle at digit_o=5 -> 5 stored, digit_o=0, no increment.
- rst_i asserted mid-entry (pos_o=2) and again mid-lockout -> next cycle all outputs 0, state SETUP, pin_vec_o=0.
